// File: rtl/linear_mac_stream.sv
// linear_mac_stream: streaming quantized linear-layer engine.
// Accumulates signed dot products of NUM_FEATURES feature vectors against one
// shared weight vector over any number of N-lane beats, MUL_PER_FEATURE lanes
// per cycle, then applies bias, fixed-point requantization, zero point and
// saturation. Valid/ready handshakes on input and output.
// Optional build macro LINEAR_MAC_RELU_EN: clamp results at Z_OUT (quantized ReLU).
module linear_mac_stream #(
    parameter int unsigned PRECISION              = 8,
    parameter int unsigned BIAS_PRECISION         = 32,
    parameter int unsigned OUTPUT_STAGE_PRECISION = 64,
    parameter int unsigned NUM_FEATURES           = 2,
    parameter int unsigned MUL_PER_FEATURE        = 8,
    parameter int unsigned N                      = 16,
    parameter logic [31:0] M_MUL                  = 32'd1073741824,
    parameter int unsigned SHIFT                  = 31,
    parameter int          Z_WEIGHTS              = 0,
    parameter int          Z_OUT                  = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic                                         in_last,
    input  logic signed [BIAS_PRECISION-1:0]             bias,
    input  logic [N-1:0][PRECISION-1:0]                  weights_in,
    input  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] features,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [NUM_FEATURES-1:0][PRECISION-1:0]       out
);

    localparam int unsigned PASSES   = N / MUL_PER_FEATURE;
    localparam int unsigned PASS_W   = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned OSP      = OUTPUT_STAGE_PRECISION;
    localparam int unsigned PROD_W   = 2 * PRECISION + 1;
    localparam int unsigned WIN_BITS = MUL_PER_FEATURE * PRECISION;

    localparam logic [PASS_W-1:0]        LAST_PASS = PASS_W'(PASSES - 1);
    localparam logic signed [PRECISION:0] ZW       = (PRECISION + 1)'(Z_WEIGHTS);
    localparam logic signed [OSP-1:0]    ONE       = OSP'(1);
    localparam logic signed [OSP-1:0]    ROUND     = ONE <<< (SHIFT - 1);
    localparam logic signed [OSP-1:0]    ZOUT_EXT  = OSP'(Z_OUT);
    localparam logic signed [OSP-1:0]    SAT_MAX   = (ONE <<< (PRECISION - 1)) - ONE;
    localparam logic signed [OSP-1:0]    SAT_MIN   = -(ONE <<< (PRECISION - 1));
    localparam logic signed [OSP-1:0]    M_EXT     = {{(OSP - 32){1'b0}}, M_MUL};

    typedef enum logic [1:0] {IDLE, MAC, REQ, OUT} state_t;

    state_t                                       state;
    logic [N-1:0][PRECISION-1:0]                  w_q;
    logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] f_q;
    logic                                         last_q;
    logic                                         first_q;
    logic [PASS_W-1:0]                            pass_q;
    logic [NUM_FEATURES-1:0][BIAS_PRECISION-1:0]  acc_q;
    logic [NUM_FEATURES-1:0][BIAS_PRECISION-1:0]  pass_sum;
    logic [NUM_FEATURES-1:0][PRECISION-1:0]       req_out;

    // (weight - Z_WEIGHTS) * feature, sign-extended to accumulator width
    function automatic logic [BIAS_PRECISION-1:0] lane_product(
        input logic [PRECISION-1:0] w,
        input logic [PRECISION-1:0] x
    );
        logic signed [PRECISION:0] wz;
        logic signed [PROD_W-1:0]  p;
        wz = $signed({1'b0, w}) - ZW;
        p  = wz * $signed(x);
        return {{(BIAS_PRECISION - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Rounded multiply-shift, zero point, optional ReLU, saturation
    function automatic logic [PRECISION-1:0] requant(input logic [BIAS_PRECISION-1:0] acc);
        logic signed [OSP-1:0] v;
        v = {{(OSP - BIAS_PRECISION){acc[BIAS_PRECISION-1]}}, acc};
        v = (v * M_EXT + ROUND) >>> SHIFT;
        v = v + ZOUT_EXT;
`ifdef LINEAR_MAC_RELU_EN
        if (v < ZOUT_EXT) v = ZOUT_EXT;
`else
        v = v;
`endif
        if (v > SAT_MAX)
            v = SAT_MAX;
        else if (v < SAT_MIN)
            v = SAT_MIN;
        return v[PRECISION-1:0];
    endfunction

    // Sum of the MUL_PER_FEATURE products in the current lane window.
    // The registered beat is shifted down one window per pass, so the
    // multipliers always read lanes 0..MUL_PER_FEATURE-1 instead of muxing.
    always_comb begin
        for (int unsigned f = 0; f < NUM_FEATURES; f++) begin
            pass_sum[f] = '0;
            for (int unsigned m = 0; m < MUL_PER_FEATURE; m++)
                pass_sum[f] = pass_sum[f] + lane_product(w_q[m], f_q[f][m]);
        end
    end

    // Requantized value of each accumulator
    always_comb begin
        for (int unsigned f = 0; f < NUM_FEATURES; f++)
            req_out[f] = requant(acc_q[f]);
    end

    // Control FSM with registered handshake outputs, accumulators and result.
    // out_valid rises one cycle after out is loaded in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            acc_q     <= '0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            pass_q    <= '0;
            w_q       <= '0;
            f_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        w_q      <= weights_in;
                        f_q      <= features;
                        last_q   <= in_last;
                        pass_q   <= '0;
                        in_ready <= 1'b0;
                        if (first_q) begin
                            for (int unsigned f = 0; f < NUM_FEATURES; f++)
                                acc_q[f] <= bias;
                            first_q <= 1'b0;
                        end
                        state <= MAC;
                    end
                end
                MAC: begin
                    for (int unsigned f = 0; f < NUM_FEATURES; f++) begin
                        acc_q[f] <= acc_q[f] + pass_sum[f];
                        f_q[f]   <= f_q[f] >> WIN_BITS;
                    end
                    w_q    <= w_q >> WIN_BITS;
                    pass_q <= pass_q + 1'b1;
                    if (pass_q == LAST_PASS) begin
                        if (last_q) begin
                            state <= REQ;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                REQ: begin
                    out   <= req_out;
                    state <= OUT;
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        first_q   <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
